// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller and the shared ALU:
// opcode encodings, controller FSM states and default widths.
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_CTRL_W = 3;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_SRAI = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two requests, pointer
// register moves to the non-granted requester on each advance strobe.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       rr_ptr
);

    always_comb begin
        grant = 2'b00;
        case ({req1, req0})
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Granting requester 0 hands priority to 1, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            rr_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two valid/ready requesters.
// Optional multi-cycle MUL issue is enabled by ALU_SHARE_MUL_STALL_EN.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int CTRL_W  = ALU_CTRL_W,
    parameter int MUL_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [WIDTH-1:0]  req0_data1_i,
    input  logic [WIDTH-1:0]  req0_data2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [WIDTH-1:0]  req1_data1_i,
    input  logic [WIDTH-1:0]  req1_data2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [WIDTH-1:0]  rsp0_data_o,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [WIDTH-1:0]  rsp1_data_o,
    output logic [WIDTH-1:0]  alu_data1_o,
    output logic [WIDTH-1:0]  alu_data2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_data_i,
    output logic              busy_o
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_share_ctrl: MUL_LAT must be in 1..15");
    end

    state_t            state_q, state_d;
    logic [1:0]        grant;
    logic              rr_ptr;
    logic              take;
    logic              issue_done;
    logic              gnt_q;
    logic [WIDTH-1:0]  op1_q, op2_q, result_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [WIDTH-1:0]  sel_d1, sel_d2;
    logic [CTRL_W-1:0] sel_ctrl;

    // Readies follow the grant combinationally, so any valid in IDLE is taken.
    assign take     = (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    assign sel_d1   = grant[1] ? req1_data1_i : req0_data1_i;
    assign sel_d2   = grant[1] ? req1_data2_i : req0_data2_i;
    assign sel_ctrl = grant[1] ? req1_ctrl_i  : req0_ctrl_i;

    rr_arb2 u_arb (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .req0    (req0_valid_i),
        .req1    (req1_valid_i),
        .advance (take),
        .grant   (grant),
        .rr_ptr  (rr_ptr)
    );

`ifdef ALU_SHARE_MUL_STALL_EN
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT);
    logic [3:0] mul_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mul_cnt_q <= '0;
        end else if (take) begin
            mul_cnt_q <= (sel_ctrl == CTRL_W'(OP_MUL)) ? MUL_CNT_INIT : '0;
        end else if ((state_q == ISSUE) && (mul_cnt_q != '0)) begin
            mul_cnt_q <= mul_cnt_q - 4'd1;
        end
    end

    assign issue_done = (mul_cnt_q == '0);
`else
    assign issue_done = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        alu_data1_o  = '0;
        alu_data2_o  = '0;
        alu_ctrl_o   = '0;
        case (state_q)
            IDLE: begin
                req0_ready_o = grant[0];
                req1_ready_o = grant[1];
                if (take) state_d = ISSUE;
            end
            ISSUE: begin
                alu_data1_o = op1_q;
                alu_data2_o = op2_q;
                alu_ctrl_o  = ctrl_q;
                if (issue_done) state_d = RESP;
            end
            RESP: begin
                rsp0_valid_o = !gnt_q;
                rsp1_valid_o = gnt_q;
                if (gnt_q ? rsp1_ready_i : rsp0_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp0_data_o = rsp0_valid_o ? result_q : '0;
    assign rsp1_data_o = rsp1_valid_o ? result_q : '0;
    assign busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gnt_q  <= grant[1];
                op1_q  <= sel_d1;
                op2_q  <= sel_d2;
                ctrl_q <= sel_ctrl;
            end
            if ((state_q == ISSUE) && issue_done) begin
                result_q <= alu_data_i;
            end
        end
    end

    a_grant_follows_ptr : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (take && req0_valid_i && req1_valid_i) |-> grant[rr_ptr]);

endmodule
